// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule expander: accepts one padded 512-bit block and
// streams the 64 schedule words W[0..63] over a valid/ready port.
module sha256_msg_schedule (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_data,
  output logic [5:0]   w_idx,
  output logic         w_last
);

  // Handshake rule for both ports: a transfer happens on the rising edge where
  // valid && ready; once asserted, valid is never retracted and the payload is
  // held stable until that transfer.

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t      state_q;
  logic        blk_ready_q;
  logic        w_valid_q;
  logic [5:0]  idx_q;
  logic [31:0] win_q [16];

  logic        blk_fire;
  logic        w_fire;
  logic        last_word;
  logic [31:0] next_w;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  assign blk_fire  = (state_q == S_IDLE) && blk_ready_q && blk_valid;
  assign w_fire    = (state_q == S_EMIT) && w_valid_q && w_ready;
  assign last_word = (idx_q == 6'd63);

  // Window holds W[t-16..t-1] with win_q[0] the oldest, so the taps below are
  // W[t-2], W[t-7], W[t-15] and W[t-16].
  assign next_w = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      blk_ready_q <= 1'b0;
      w_valid_q   <= 1'b0;
      idx_q       <= 6'd0;
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= 32'd0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (blk_fire) begin
            for (int i = 0; i < 16; i++) begin
              win_q[i] <= blk_data[511 - 32*i -: 32];
            end
            idx_q       <= 6'd0;
            w_valid_q   <= 1'b1;
            blk_ready_q <= 1'b0;
            state_q     <= S_EMIT;
          end else begin
            blk_ready_q <= 1'b1;
          end
        end
        S_EMIT: begin
          if (w_fire) begin
            for (int i = 0; i < 15; i++) begin
              win_q[i] <= win_q[i+1];
            end
            win_q[15] <= next_w;
            // Index parks at 63 on the final word; it is only reloaded by the next block.
            if (last_word) begin
              w_valid_q   <= 1'b0;
              blk_ready_q <= 1'b1;
              state_q     <= S_IDLE;
            end else begin
              idx_q <= idx_q + 6'd1;
            end
          end
        end
        default: begin
          state_q     <= S_IDLE;
          blk_ready_q <= 1'b0;
          w_valid_q   <= 1'b0;
        end
      endcase
    end
  end

  assign blk_ready = blk_ready_q;
  assign w_valid   = w_valid_q;
  assign w_data    = win_q[0];
  assign w_idx     = idx_q;
  assign w_last    = w_valid_q && last_word;

endmodule

// File: doc/sha256_msg_schedule.md
SHA256_MSG_SCHEDULE -- requirements
Module: sha256_msg_schedule

Interface
REQ-001 SHALL have no parameters; all widths are fixed by SHA-256.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 blk_valid  input  1  upstream padder offers one padded 512-bit block.
REQ-005 blk_ready  output  1  block accepted on the edge where blk_valid && blk_ready.
REQ-006 blk_data  input  512  padded block, word M0 in bits [511:480], M15 in bits [31:0], big-endian.
REQ-007 w_valid  output  1  w_data/w_idx hold a valid schedule word.
REQ-008 w_ready  input  1  downstream compression core consumes word on the edge where w_valid && w_ready.
REQ-009 w_data  output  32  schedule word W[w_idx].
REQ-010 w_idx  output  6  round index 0..63 of w_data.
REQ-011 w_last  output  1  high together with w_valid when w_idx==63.

Function
REQ-012 SHALL implement FSM with states IDLE and EMIT.
REQ-013 IDLE: blk_ready=1, w_valid=0; on block handshake load M0..M15 into 16-word window win[0..15], set w_idx=0, go to EMIT; blk_ready drops the same edge.
REQ-014 Latency: W[0] SHALL appear with w_valid=1 in the cycle immediately after the block-handshake edge.
REQ-015 EMIT: w_valid=1, w_data=win[0], blk_ready=0; blk_valid and blk_data ignored.
REQ-016 On each word handshake: shift window down (win[i]<=win[i+1]), win[15]<=s1(win[14])+win[9]+s0(win[1])+win[0], w_idx<=w_idx+1.
REQ-017 s0(x)=rotr7(x)^rotr18(x)^shr3(x); s1(x)=rotr17(x)^rotr19(x)^shr10(x); all additions modulo 2^32, carries discarded.
REQ-018 Without a handshake (w_ready=0), w_data, w_idx, w_last and the window SHALL hold unchanged; w_valid SHALL stay 1 (no retraction).
REQ-019 Handshake with w_idx==63: go to IDLE, w_valid=0, blk_ready=1 next cycle; w_idx SHALL NOT wrap to 0 while w_valid=1.
REQ-020 Back-to-back blocks: next block SHALL NOT be accepted in the same cycle as word 63's handshake; minimum block period 65 cycles at w_ready=1.
REQ-021 w_last SHALL equal w_valid && (w_idx==63).
REQ-022 blk_valid rising in EMIT SHALL be held off (blk_ready=0) and accepted in the first IDLE cycle.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, blk_ready=0, w_valid=0, w_last=0, w_idx=0, w_data=0, window cleared, independent of clk.
REQ-024 blk_ready SHALL rise on the first rising clk edge with rst_n high.
REQ-025 Reset mid-EMIT SHALL abandon the block; no further words of it emitted after release.

Verification
REQ-026 "abc" block (61626380, 14 x 00000000, 00000018), w_ready=1 -> W0=61626380, W15=00000018, W16=61626380, W17=000F0000, W63=12B1EDEB, w_last only at idx 63, 64 consecutive valid cycles.
REQ-027 Same block, w_ready toggled pseudo-randomly -> identical 64-word sequence, w_data/w_idx stable during every stall.
REQ-028 blk_valid held high continuously with two blocks -> second accepted exactly one cycle after word-63 handshake of first; blk_ready=0 throughout EMIT.
REQ-029 rst_n pulsed low at w_idx=30 -> outputs zero asynchronously, blk_ready=1 one edge after release, next block starts at w_idx=0 with correct W0.
REQ-030 All-ones block (16 x FFFFFFFF) -> W16=(s1(FFFFFFFF)+FFFFFFFF+s0(FFFFFFFF)+FFFFFFFF) mod 2^32 matching software model, confirming carry discard.
